// File: rtl/fix_point_div_seq.sv
// fix_point_div_seq: sequential signed Q(WIDTH-FRAC).FRAC divider, restoring radix-2,
// one quotient bit per cycle, saturating, with divide-by-zero detection.
// Latency: WIDTH+FRAC cycles from accept to out_valid (WIDTH+FRAC+1 when
// FIX_POINT_DIV_ROUND_EN is defined); 1 cycle when B is zero.
// Backpressure: in_ready is low from accept until the result is taken; out, div_by_zero
// and overflow hold stable while out_valid is high and out_ready is low.
//
// Optional macro FIX_POINT_DIV_ROUND_EN: computes one guard bit and rounds the
// magnitude half-up (ties away from zero) before saturation.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready operand handshake; A = dividend, B = divisor (signed Q)
//   out_valid/out_ready result handshake; out = quotient (signed Q)
//   div_by_zero       B was zero (qualified by out_valid)
//   overflow          result was saturated (qualified by out_valid)
module fix_point_div_seq #(
  parameter int WIDTH = 16,
  parameter int FRAC  = WIDTH / 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             div_by_zero,
  output logic             overflow
);

`ifdef FIX_POINT_DIV_ROUND_EN
  localparam int G = 1;   // guard bit
`else
  localparam int G = 0;
`endif

  // DW: quotient bits produced; MW: magnitude width with headroom for the rounding carry
  localparam int DW = WIDTH + FRAC + G;
  localparam int MW = WIDTH + FRAC + 1;
  localparam int CW = $clog2(DW + 1);

  localparam logic [WIDTH-1:0] MAXP_W = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINN_W = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [MW-1:0]    MAXP_M = {{(FRAC+2){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [MW-1:0]    MAXN_M = {{(FRAC+1){1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e           state_q;
  logic             sign_q;
  logic             bz_q;
  logic [WIDTH-1:0] absb_q;
  logic [WIDTH-1:0] rem_q;
  logic [DW-1:0]    dq_q;      // dividend bits shift out the top, quotient bits shift in the bottom
  logic [CW-1:0]    cnt_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_q;
  logic             dbz_q;
  logic             ovf_q;

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             ge;
  logic [WIDTH-1:0] rem_d;
  logic [DW-1:0]    dq_d;
  logic [MW-1:0]    mag;
  logic [WIDTH-1:0] res_d;
  logic             ovf_d;
  logic [WIDTH-1:0] dbz_res_d;

  // Most negative input maps to 2^(WIDTH-1), which still fits WIDTH unsigned bits
  always_comb begin
    abs_a = A[WIDTH-1] ? (~A + WIDTH'(1)) : A;
    abs_b = B[WIDTH-1] ? (~B + WIDTH'(1)) : B;
  end

  // One restoring step: the borrow out of diff tells whether |B| fits the remainder.
  // The shifted remainder is always below 2^WIDTH, so WIDTH+1 bits capture the borrow.
  always_comb begin
    rem_sh = {rem_q, dq_q[DW-1]};
    diff   = rem_sh - {1'b0, absb_q};
    ge     = ~diff[WIDTH];
    rem_d  = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    dq_d   = {dq_q[DW-2:0], ge};
  end

  // Result formation from the final quotient (dq_d on the last iteration)
  always_comb begin
`ifdef FIX_POINT_DIV_ROUND_EN
    mag = {1'b0, dq_d[DW-1:1]} + MW'(dq_d[0]);
`else
    mag = {1'b0, dq_d};
`endif
    res_d = mag[WIDTH-1:0];
    ovf_d = 1'b0;
    if (sign_q) begin
      if (mag > MAXN_M) begin
        res_d = MINN_W;
        ovf_d = 1'b1;
      end else begin
        // -2^(WIDTH-1) and -0 both come out right from the modular negate
        res_d = WIDTH'(0) - mag[WIDTH-1:0];
      end
    end else if (mag > MAXP_M) begin
      res_d = MAXP_W;
      ovf_d = 1'b1;
    end
  end

  // With B == 0 the sign register holds A's sign, and dq_q is nonzero iff A is
  always_comb begin
    dbz_res_d = '0;
    if (dq_q != '0) dbz_res_d = sign_q ? MINN_W : MAXP_W;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      bz_q        <= 1'b0;
      absb_q      <= '0;
      rem_q       <= '0;
      dq_q        <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sign_q     <= A[WIDTH-1] ^ B[WIDTH-1];
            bz_q       <= (B == '0);
            absb_q     <= abs_b;
            dq_q       <= DW'(abs_a) << (FRAC + G);
            rem_q      <= '0;
            cnt_q      <= CW'(DW - 1);
            in_ready_q <= 1'b0;
            state_q    <= CALC;
          end
        end
        CALC: begin
          if (bz_q) begin
            out_q       <= dbz_res_d;
            dbz_q       <= 1'b1;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            rem_q <= rem_d;
            dq_q  <= dq_d;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == '0) begin
              out_q       <= res_d;
              ovf_q       <= ovf_d;
              dbz_q       <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out         = out_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_fix_point_div_seq.sv
// tb_fix_point_div_seq: directed bench for fix_point_div_seq at WIDTH=16, FRAC=8.
// Drives inputs 1 time unit after the rising edge and samples outputs there too.
// Expected values are hand-computed; rounding-dependent ones follow FIX_POINT_DIV_ROUND_EN.
module tb_fix_point_div_seq;

`ifdef FIX_POINT_DIV_ROUND_EN
  localparam int LAT = 25;
  localparam logic [15:0] E_2_3   = 16'h00AB;
  localparam logic [15:0] E_M2_3  = 16'hFF55;
  localparam logic [15:0] E_M2_M3 = 16'h00AB;
  localparam logic [15:0] E_TINY  = 16'hFFFF;
`else
  localparam int LAT = 24;
  localparam logic [15:0] E_2_3   = 16'h00AA;
  localparam logic [15:0] E_M2_3  = 16'hFF56;
  localparam logic [15:0] E_M2_M3 = 16'h00AA;
  localparam logic [15:0] E_TINY  = 16'h0000;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a_s;
  logic [15:0] b_s;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_s;
  logic        dbz;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  fix_point_div_seq #(.WIDTH(16), .FRAC(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .A          (a_s),
    .B          (b_s),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out        (out_s),
    .div_by_zero(dbz),
    .overflow   (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operands once the divider is ready; returns after the accept edge
  task automatic start_op(input logic [15:0] a, input logic [15:0] b);
    int w;
    w = 0;
    while (!in_ready && w < 100) begin
      step();
      w++;
    end
    a_s = a;
    b_s = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      step();
      lat++;
    end
  endtask

  task automatic handoff(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, " after handoff vld/rdy"}, 32'({out_valid, in_ready}), 32'h1);
  endtask

  task automatic vec(input string tag, input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] eo, input logic eovf, input logic edbz,
                     input int elat);
    int lat;
    start_op(a, b);
    wait_done(lat);
    chk({tag, " latency"}, 32'(lat), 32'(elat));
    chk({tag, " out"}, 32'(out_s), 32'(eo));
    chk({tag, " overflow"}, 32'(ovf), 32'(eovf));
    chk({tag, " div_by_zero"}, 32'(dbz), 32'(edbz));
    handoff(tag);
  endtask

  initial begin
    int lat;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_s       = '0;
    b_s       = '0;
    repeat (3) step();

    chk("reset in_ready", 32'(in_ready), 32'h1);
    chk("reset out_valid", 32'(out_valid), 32'h0);
    chk("reset out", 32'(out_s), 32'h0);
    chk("reset flags", 32'({dbz, ovf}), 32'h0);
    rst = 1'b0;
    step();

    // Main function and signs
    vec("3/2",     16'h0300, 16'h0200, 16'h0180, 1'b0, 1'b0, LAT);
    vec("2/3",     16'h0200, 16'h0300, E_2_3,    1'b0, 1'b0, LAT);
    vec("-2/3",    16'hFE00, 16'h0300, E_M2_3,   1'b0, 1'b0, LAT);
    vec("-2/-3",   16'hFE00, 16'hFD00, E_M2_M3,  1'b0, 1'b0, LAT);
    vec("0/-1",    16'h0000, 16'hFF00, 16'h0000, 1'b0, 1'b0, LAT);
    vec("tiny neg",16'hFFFF, 16'h0200, E_TINY,   1'b0, 1'b0, LAT);

    // Saturation boundaries
    vec("sat pos",   16'h7F00, 16'h0010, 16'h7FFF, 1'b1, 1'b0, LAT);
    vec("min/1",     16'h8000, 16'h0100, 16'h8000, 1'b0, 1'b0, LAT);
    vec("min/-1",    16'h8000, 16'hFF00, 16'h7FFF, 1'b1, 1'b0, LAT);

    // Divide by zero
    vec("dbz pos",  16'h0100, 16'h0000, 16'h7FFF, 1'b0, 1'b1, 1);
    vec("dbz neg",  16'hFF00, 16'h0000, 16'h8000, 1'b0, 1'b1, 1);
    vec("dbz zero", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 1);

    // Backpressure: result held, in_ready low, stray in_valid ignored
    start_op(16'h0300, 16'h0200);
    wait_done(lat);
    chk("bp latency", 32'(lat), 32'(LAT));
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        a_s = 16'h1234;
        b_s = 16'h0100;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      step();
      chk("bp hold out", 32'(out_s), 32'h0180);
      chk("bp hold vld/rdy/flags", 32'({out_valid, in_ready, dbz, ovf}), 32'h8);
    end
    in_valid = 1'b0;
    handoff("bp");
    chk("bp out kept after handoff", 32'(out_s), 32'h0180);
    step();
    chk("bp no stray accept", 32'(in_ready), 32'h1);
    vec("bp next op", 16'h0200, 16'h0300, E_2_3, 1'b0, 1'b0, LAT);

    // Reset in the middle of CALC abandons the operation
    start_op(16'h7F00, 16'h0010);
    repeat (10) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst out_valid", 32'(out_valid), 32'h0);
    chk("midrst in_ready", 32'(in_ready), 32'h1);
    chk("midrst out", 32'(out_s), 32'h0);
    vec("after midrst", 16'h0300, 16'h0200, 16'h0180, 1'b0, 1'b0, LAT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fix_point_div_seq.md
Name: fix_point_div_seq

Overview:
- Sequential signed fixed-point divider in Q(WIDTH-FRAC).FRAC two's-complement format, generalised in word width and fraction bits.
- Radix-2 restoring division, one quotient bit per cycle, with saturation, divide-by-zero detection and valid/ready handshakes on both sides.
- Sits beside the combinational add, subtract and multiply fixed-point operators in the neuron datapath. It replaces the single-cycle shift-add divide and is exact to 1 LSB (truncation toward zero).

Parameters:
- WIDTH, 16: operand and result word width, in bits. Must be at least 4.
- FRAC, WIDTH/2: number of fractional bits. Must satisfy 0 <= FRAC < WIDTH.

Ports:
- clk, input, 1: clock. All state updates on the rising edge.
- rst, input, 1: synchronous reset, active-high.
- in_valid, input, 1: A and B are valid this cycle.
- in_ready, output, 1: divider can accept an operation.
- A, input, WIDTH: dividend, signed Q format.
- B, input, WIDTH: divisor, signed Q format.
- out_valid, output, 1: result is valid.
- out_ready, input, 1: consumer accepts the result.
- out, output, WIDTH: quotient, signed Q format.
- div_by_zero, output, 1: B was 0. Qualified by out_valid.
- overflow, output, 1: result was saturated. Qualified by out_valid.

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, out=0, div_by_zero=0, overflow=0. All internal registers cleared.
- Reset during CALC or DONE abandons the operation; no output is produced.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready, latch the following and go to CALC:
    - sign = A[msb] ^ B[msb]
    - |A|, |B| as WIDTH-bit unsigned. The most negative value maps to 2^(WIDTH-1) with no wrap.
    - dividend = |A| << FRAC, WIDTH+FRAC bits
    - remainder = 0; iteration counter = WIDTH+FRAC-1
- CALC:
  - in_ready=0.
  - Each cycle: shift remainder left, bringing in the next dividend MSB. If remainder >= |B|, subtract |B| and shift in quotient bit 1, otherwise shift in 0.
  - Counter decrements. Leave after exactly WIDTH+FRAC iterations.
- Latency: the accept edge, then WIDTH+FRAC CALC cycles, after which out_valid rises. Default = 24 cycles from the accept edge to out_valid.
- Result formation on CALC exit (registered, DONE):
  - q = quotient magnitude, WIDTH+FRAC bits.
  - Positive result: if q > 2^(WIDTH-1)-1, out = 2^(WIDTH-1)-1 and overflow=1.
  - Negative result: if q > 2^(WIDTH-1), out = -2^(WIDTH-1) and overflow=1. Otherwise out = -q.
  - A zero quotient with sign=1 gives out=0 (no negative zero).
- Divide by zero, B==0:
  - Skip CALC and go from IDLE to DONE on the next cycle; latency 1.
  - div_by_zero=1, overflow=0.
  - out = 2^(WIDTH-1)-1 if A>0, -2^(WIDTH-1) if A<0, 0 if A==0.
- DONE:
  - out_valid=1. out and both flags are held stable until out_ready.
  - On out_valid & out_ready: go to IDLE, out_valid=0. out and flags keep their last values.
  - in_ready stays 0 in DONE. A new operation cannot be accepted in the same cycle as the result handoff; throughput is one operation per latency+2 cycles minimum.
- in_valid while in_ready=0 is ignored and the operands are not captured. The upstream holds in_valid until acceptance.

Optional Feature:
- Macro FIX_POINT_DIV_ROUND_EN.
- Defined:
  - One extra CALC iteration produces a guard bit; latency becomes WIDTH+FRAC+1.
  - Magnitude is rounded half-up (q + guard) before saturation and sign application, i.e. round-to-nearest, ties away from zero.
  - Rounding carry may trigger saturation and overflow.
- Undefined: truncation toward zero, latency WIDTH+FRAC, no guard logic.

Test Plan (defaults: WIDTH=16, FRAC=8):
- Basic: A=0x0300, B=0x0200 (3.0/2.0) -> out=0x0180, no flags, out_valid exactly 24 cycles after accept; 25 with FIX_POINT_DIV_ROUND_EN.
- Signs and rounding:
  - A=0x0200, B=0x0300 -> out=0x00AA truncated, 0x00AB with ROUND_EN.
  - A=0xFE00, B=0x0300 -> out=0xFF56 truncated, 0xFF55 with ROUND_EN.
  - A=0xFE00, B=0xFD00 -> out=0x00AA.
- Saturation:
  - A=0x7F00, B=0x0010 -> out=0x7FFF, overflow=1.
  - A=0x8000, B=0x0100 -> out=0x8000, overflow=0.
  - A=0x8000, B=0xFF00 -> out=0x7FFF, overflow=1.
- Divide by zero, B=0x0000:
  - A=0x0100 -> out=0x7FFF, div_by_zero=1, out_valid 1 cycle after accept.
  - A=0xFF00 -> 0x8000.
  - A=0 -> 0x0000.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out and flags stable, in_ready=0, an in_valid pulse is ignored. Then raise out_ready -> in_ready=1 on the next cycle and the next operation computes correctly.
- Reset mid-operation: assert rst at iteration 10 of CALC -> next cycle out_valid=0, in_ready=1, out=0. A subsequent 0x0300/0x0200 still yields 0x0180.
